// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a show-ahead FIFO and serialises each as a UART frame
// (start, LSB-first data, optional even parity, stop) on a registered, idle-high tx line.
// Optional feature macro: FIFO_UART_TX_PARITY_EN adds an even-parity bit (8E1 instead of 8N1).
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done_tick
);

  localparam int unsigned SW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [SW-1:0] SLast = SW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] NLast = NW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef FIFO_UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         s_q, s_d;
  logic [NW-1:0]         n_q, n_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic                  pop;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // State, counters, shift register and the registered line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Pop strobe is gated by reset so the FIFO is never drained while held in reset.
  always_comb begin
    pop = (state_q == StIdle) && !empty && reset;
  end

  // Next-state, baud/bit counting and frame sequencing.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    shreg_d      = shreg_q;
    tx_d         = tx_q;
    tx_done_tick = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          shreg_d = r_data;
          s_d     = '0;
          tx_d    = 1'b0;
          state_d = StStart;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_d = ^r_data;
`endif
        end
      end
      StStart: begin
        if (s_q == SLast) begin
          s_d     = '0;
          n_d     = '0;
          tx_d    = shreg_q[0];
          state_d = StData;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      StData: begin
        if (s_q == SLast) begin
          s_d     = '0;
          shreg_d = shreg_q >> 1;
          if (n_q == NLast) begin
`ifdef FIFO_UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            n_d  = n_q + 1'b1;
            tx_d = shreg_d[0];
          end
        end else begin
          s_d = s_q + 1'b1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      StParity: begin
        if (s_q == SLast) begin
          s_d     = '0;
          tx_d    = 1'b1;
          state_d = StStop;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (s_q == SLast) begin
          tx_done_tick = 1'b1;
          s_d          = '0;
          state_d      = StIdle;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output drive.
  always_comb begin
    rd   = pop;
    tx   = tx_q;
    busy = (state_q != StIdle);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: randomized and directed bench for fifo_uart_tx with a show-ahead FIFO
// model and a frame-timeline reference model (bit position = cycles since pop / CLKS_PER_BIT).
module tb_fifo_uart_tx;

  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = (10 + PAR) * C;

  logic       clk = 1'b0;
  logic       reset;
  logic       empty;
  logic [7:0] r_data;
  logic       rd, tx, busy, tx_done_tick;

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .empty       (empty),
    .r_data      (r_data),
    .rd          (rd),
    .tx          (tx),
    .busy        (busy),
    .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] fifo[$];
  int         rd_times[$];
  int         done_times[$];
  logic       txlog[$];
  int         busy_cnt = 0;
  // Reference model: idle, or active at cycle offset m_k within a frame carrying m_byte.
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic frame_bit(input int b, input logic [7:0] v);
    if (b == 0) return 1'b0;
    if (b <= 8) return v[b-1];
    if (PAR == 1 && b == 9) return ^v;
    return 1'b1;
  endfunction

  // One clock cycle: drive inputs at the falling edge, compare, then advance on the rising edge.
  task automatic step(input logic rst_val);
    logic       e_tx, e_rd, e_busy, e_done, rd_seen;
    logic [7:0] cap;
    reset = rst_val;
    if (!rst_val) m_active = 1'b0;
    empty = (fifo.size() == 0);
    cap = 8'h00;
    if (fifo.size() != 0) cap = fifo[0];
    r_data = cap;
    #1;
    if (!rst_val) begin
      e_tx = 1'b1; e_rd = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else if (m_active) begin
      e_tx = frame_bit(m_k / C, m_byte); e_rd = 1'b0; e_busy = 1'b1; e_done = (m_k == FL - 1);
    end else begin
      e_tx = 1'b1; e_rd = !empty; e_busy = 1'b0; e_done = 1'b0;
    end
    check("tx", {31'd0, tx}, {31'd0, e_tx});
    check("rd", {31'd0, rd}, {31'd0, e_rd});
    check("busy", {31'd0, busy}, {31'd0, e_busy});
    check("tx_done_tick", {31'd0, tx_done_tick}, {31'd0, e_done});
    rd_seen = rd;
    if (rd) rd_times.push_back(cyc);
    if (tx_done_tick) done_times.push_back(cyc);
    if (busy) busy_cnt++;
    txlog.push_back(tx);
    @(posedge clk);
    cyc++;
    if (rd_seen && fifo.size() != 0) void'(fifo.pop_front());
    if (rst_val) begin
      if (m_active) begin
        m_k++;
        if (m_k == FL) m_active = 1'b0;
      end else if (e_rd) begin
        m_active = 1'b1;
        m_k = 0;
        m_byte = cap;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  // Step until a new rd pulse is logged; an expired budget counts as a failure.
  task automatic wait_rd(input int budget, output int t);
    int n0;
    n0 = rd_times.size();
    for (int i = 0; i < budget && rd_times.size() == n0; i++) step(1'b1);
    check("rd_timeout", {31'd0, rd_times.size() > n0}, 32'd1);
    t = (rd_times.size() > n0) ? rd_times[rd_times.size()-1] : cyc;
  endtask

  function automatic logic [7:0] decode(input int p);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = txlog[p + 1 + C * (b + 1) + C / 2];
    return v;
  endfunction

  initial begin
    int p, p2, nd, nr;
    logic [9:0] fr;
    reset = 1'b0;
    empty = 1'b1;
    r_data = '0;
    @(negedge clk);

    // Reset held low with an empty FIFO.
    for (int i = 0; i < 3; i++) step(1'b0);

    // Single byte 0x05.
    busy_cnt = 0;
    nd = done_times.size();
    fifo.push_back(8'h05);
    wait_rd(10, p);
    run(FL + 2);
    for (int b = 0; b < 10; b++) fr[b] = txlog[p + 1 + C * b];
    check("frame_0x05", {22'd0, fr}, 32'h20A);
    check("busy_len", busy_cnt, (PAR == 1) ? 32'd44 : 32'd40);
    check("done_count", done_times.size() - nd, 32'd1);
    check("done_pos", done_times[done_times.size()-1] - p, (PAR == 1) ? 32'd44 : 32'd40);
    check("fifo_drained", {31'd0, empty}, 32'd1);

    // Empty held for 100 cycles.
    nr = rd_times.size();
    run(100);
    check("no_rd_when_empty", rd_times.size() - nr, 32'd0);

    // Back-to-back 0x08, 0x02.
    fifo.push_back(8'h08);
    fifo.push_back(8'h02);
    wait_rd(10, p);
    wait_rd(100, p2);
    check("b2b_gap", p2 - p, (PAR == 1) ? 32'd45 : 32'd41);
    run(FL + 2);
    check("b2b_byte0", {24'd0, decode(p)}, 32'h08);
    check("b2b_byte1", {24'd0, decode(p2)}, 32'h02);

    // Reset during data bit 3 of 0x09, then 0x03 queued.
    fifo.push_back(8'h09);
    wait_rd(10, p);
    while (cyc < p + 1 + 4 * C + 1) step(1'b1);
    nd = done_times.size();
    step(1'b0);
    step(1'b0);
    fifo.push_back(8'h03);
    step(1'b0);
    wait_rd(3, p);
    check("rd_after_release", p, cyc - 1);
    run(FL + 2);
    check("no_tick_aborted", done_times.size() - nd, 32'd1);
    check("resume_byte", {24'd0, decode(p)}, 32'h03);

    // Frame length and parity on 0x07, then 0x05.
    fifo.push_back(8'h07);
    wait_rd(10, p);
    run(FL + 2);
    check("len_0x07", done_times[done_times.size()-1] - p, (PAR == 1) ? 32'd44 : 32'd40);
    check("byte_0x07", {24'd0, decode(p)}, 32'h07);
`ifdef FIFO_UART_TX_PARITY_EN
    check("parity_0x07", {31'd0, txlog[p + 1 + C * 9 + C / 2]}, 32'd1);
    fifo.push_back(8'h05);
    wait_rd(10, p);
    run(FL + 2);
    check("parity_0x05", {31'd0, txlog[p + 1 + C * 9 + C / 2]}, 32'd0);
`endif

    // Random traffic, occasional bursts and an occasional mid-stream reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) fifo.push_back(8'($urandom));
      if ($urandom_range(0, 499) == 0) step(1'b0);
      else step(1'b1);
    end
    run(20 * FL);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the asymmetric FIFO: pops one byte at a time from the FIFO's narrow read port and serialises it as an 8N1 UART frame on a single `tx` line. It sits between the FIFO's `r_data`/`rd`/`empty` interface and the board TX pin. It issues exactly one `rd` pulse per transmitted byte and never pops an empty FIFO.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame; must match the FIFO read width.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.

- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset. Asserting it (0) forces the reset state immediately.
- `empty` input, 1 bit: FIFO empty flag.
- `r_data` input, DATA_WIDTH bits: FIFO head word. It is valid whenever `empty`=0, with show-ahead (first-word-fall-through) behaviour.
- `rd` output, 1 bit: FIFO pop strobe, one cycle per byte.
- `tx` output, 1 bit: serial line, registered, idle high.
- `busy` output, 1 bit: high while a frame is in progress.
- `tx_done_tick` output, 1 bit: one-cycle pulse in the last cycle of the stop bit.

## Operation
- **States:** IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- **Counters:**
  - Baud counter `s`: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - Bit index `n`: width $clog2(DATA_WIDTH); counts 0..DATA_WIDTH-1.
- **Reset values:** state=IDLE, `tx`=1, `rd`=0, `busy`=0, `tx_done_tick`=0, `s`=0, `n`=0, shift register=0.
- **IDLE:**
  - `rd` = (state==IDLE) && !`empty`. It is combinational, so it is high in the same cycle `empty` is seen low.
  - On that edge: latch `r_data` into the shift register, clear `s`, register `tx`←0, go to START.
- **START:** hold `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with `n`=0.
- **DATA:**
  - `tx` = shift register bit 0, LSB first.
  - On each `s` wrap: shift right and increment `n`.
  - After bit DATA_WIDTH-1 wraps: go to PARITY if present, otherwise STOP.
- **STOP:** `tx`=1 for CLKS_PER_BIT cycles. `tx_done_tick`=1 in the final cycle (`s`==CLKS_PER_BIT-1). Then go to IDLE.
- **`busy`:** equals state != IDLE.
- **Inputs ignored outside IDLE:** `empty` and `r_data` are ignored in all other states; the byte is captured at pop time.
- **Reset mid-frame:** `tx` returns to 1 asynchronously. The in-flight byte is discarded, since it was already popped. No `tx_done_tick` is issued.

## Timing
- **Pop to line:** `rd` pulse and the `tx` falling edge occur on the same clock edge.
- **Frame length:** (2 + DATA_WIDTH) × CLKS_PER_BIT cycles; add CLKS_PER_BIT when parity is enabled.
- **Back-to-back frames:**
  - After STOP the block spends exactly one cycle in IDLE.
  - If `empty`=0 in that cycle, the next `rd` pulse and start bit follow.
  - Consecutive `rd` pulses are therefore (frame length + 1) cycles apart.
- **`rd` guarantees:** never asserted while `empty`=1, and never asserted outside IDLE.
- **Reset release:** the first pop can occur on the first rising edge after `reset` deasserts.

## Configuration
- **Macro `FIFO_UART_TX_PARITY_EN`:**
  - **Defined:** the PARITY state is compiled in. It transmits the even-parity bit (XOR of the payload bits, computed at capture) for CLKS_PER_BIT cycles between DATA and STOP. The frame becomes 8E1.
  - **Undefined:** there is no PARITY state and no parity logic. DATA goes directly to STOP. The frame is 8N1.

## Test plan
Bench uses CLKS_PER_BIT=4 and a behavioural show-ahead FIFO model.

1. **Reset:** hold `reset`=0 for 3 cycles. Require `tx`=1, `rd`=0, `busy`=0, `tx_done_tick`=0 throughout.
2. **Single byte:** push 0x05.
   - Require one `rd` pulse.
   - `tx` levels, each held 4 cycles: 0 (start), 1,0,1,0,0,0,0,0, then 1 (stop).
   - `busy` high for 40 cycles; `tx_done_tick` in cycle 40; `empty` returns to 1.
3. **Empty held:** `empty`=1 for 100 cycles. Require no `rd` pulse and `tx` constantly 1.
4. **Back-to-back:** push 0x08 then 0x02.
   - Require two `rd` pulses exactly 41 cycles apart.
   - Decoded bytes 0x08, 0x02 in order.
5. **Reset mid-frame:** push 0x09, pull `reset` low during data bit 3.
   - Require `tx`=1 immediately and no `tx_done_tick`.
   - After release, with 0x03 queued: new `rd` pulse and a correct 0x03 frame.
6. **Parity (macro defined):** push 0x07.
   - Require parity bit 1 after the data bits and a frame of 44 cycles.
   - Then push 0x05: require parity bit 0.
   - With the macro undefined, the 0x07 frame is 40 cycles.
